seq_alu: RTL and testbench
==========================

# seq_alu

Handshaked, parametrised successor to the datapath's 8-bit combinational ALU. It accepts one operation per transfer, registers the result and status flags, and adds NE/SLT compares and an iterative multiply. It sits between the register-file read stage and the writeback/branch stage. All outputs are registered and held until the consumer accepts them.

## Interface
- WIDTH, 8: operand/result width (≥4).
- OPW, 4: opcode width (fixed encoding below, upper codes unused if OPW>4).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted when in_valid & in_ready at clk edge.
- opcode  in  OPW  operation select.
- alu_src  in  1  1: execute opcode; 0: result forced 0, flags 0 (still handshaked).
- data_in1, data_in2  in  WIDTH  operands A, B.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- result  out  WIDTH  registered result.
- compare  out  1  branch condition (EQ/NE/SLT ops only, else 0).
- zero, carry, negative, overflow  out  1 each  status flags.
- busy  out  1  high in BUSY state.

## Operation
- Encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHR (logical), 0110 SHL, 0111 EQ, 1000 NE, 1001 ADD (load addr), 1010 ADD (store addr), 1011 MUL, 1100 SLT (signed A<B); other codes: result 0, all flags 0.
- ADD/1001/1010: result = (A+B) mod 2^WIDTH; carry = carry-out; overflow = signed overflow.
- SUB: result = (A−B) mod 2^WIDTH; carry = borrow (A<B unsigned); overflow = signed overflow.
- Shifts: amount = B unsigned; B ≥ WIDTH gives result 0. carry, overflow = 0.
- Logic ops, shifts, MUL: carry = overflow = 0.
- EQ/NE/SLT: compare = condition; result = 0; carry = overflow = 0.
- MUL: low WIDTH bits of unsigned A×B, computed by shift-add, one multiplier bit per cycle.
- zero = (result == 0); negative = result[WIDTH−1]; compute both for every op, including compares. Exception: alu_src=0 forces all flags to 0, including zero.
- FSM states:
  - IDLE: on accept of a single-cycle op → DONE; on accept of MUL with alu_src=1 → BUSY, counter = WIDTH.
  - BUSY: counter decrements each cycle; on the final step → DONE.
  - DONE: out_valid=1; on out_ready with no new accept → IDLE; on out_ready with a new accept → DONE or BUSY as for IDLE.
- in_ready = rst_n & (IDLE | (DONE & out_ready)); combinational from state and out_ready.
- result, flags and compare change only on the edge that enters DONE. They are stable while out_valid=1 & out_ready=0.

## Timing
- Reset (rst_n low at an edge): state IDLE, out_valid 0, result 0, compare/zero/carry/negative/overflow 0, busy 0, counter 0. in_ready is 0 while rst_n is low.
- Reset mid-MUL or mid-DONE: the operation is discarded with no output.
- Single-cycle op accepted at edge E0: out_valid high after E0 (latency 1).
- MUL accepted at E0: busy high after E0; out_valid high after E0+WIDTH; busy low on that same edge.
- Back-to-back throughput for single-cycle ops is 1/cycle when out_ready is held high.
- While BUSY: in_ready=0. out_ready is ignored and out_valid stays 0.
- Inputs are sampled only on the accept edge. Operand changes afterwards have no effect, including during BUSY.

## Test plan
- Reset: hold rst_n=0 for 2 edges with in_valid=1 → in_ready=0, out_valid=0, all outputs 0. Release → in_ready=1.
- ADD/SUB flags (WIDTH=8), each with out_ready=1:
  - ADD 0x7F+0x01 → result 0x80, negative=1, overflow=1, carry=0.
  - ADD 0xFF+0x01 → result 0x00, zero=1, carry=1.
  - SUB 0x03−0x05 → result 0xFE, carry=1, negative=1.
- Shift/compare:
  - SHL 0x81 by 1 → result 0x02.
  - SHR 0x80 by 9 → result 0x00, zero=1.
  - NE 5,5 → compare=0.
  - SLT 0xFF,0x01 → compare=1.
  - EQ with alu_src=0 → compare=0, result 0.
- MUL 13×11 (WIDTH=8): out_valid exactly 8 cycles after accept, result 0x8F. busy high for cycles 1–8. in_ready=0 throughout. Operands changed mid-op are ignored.
- Backpressure: out_ready=0 for 3 cycles after ADD 1+2 → result 3 held, in_ready=0. Then raise out_ready with a SUB 9−4 pending → SUB accepted on the same edge, next result 5.
- Reset asserted 3 cycles into a MUL → out_valid never rises. After release, a fresh ADD 2+2 returns 4 at latency 1.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked registered ALU with NE/SLT compares and an iterative shift-add multiply.
// State | meaning: IDLE | waiting for a request; BUSY | multiply in progress; DONE | result held until consumer accepts.
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   opcode,
   input  logic             alu_src,
   input  logic [WIDTH-1:0] data_in1,
   input  logic [WIDTH-1:0] data_in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             compare,
   output logic             zero,
   output logic             carry,
   output logic             negative,
   output logic             overflow,
   output logic             busy
);

   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH:0] W_LIM = (WIDTH + 1)'(WIDTH);

   localparam logic [OPW-1:0] OP_ADD = OPW'(0);
   localparam logic [OPW-1:0] OP_SUB = OPW'(1);
   localparam logic [OPW-1:0] OP_AND = OPW'(2);
   localparam logic [OPW-1:0] OP_OR  = OPW'(3);
   localparam logic [OPW-1:0] OP_XOR = OPW'(4);
   localparam logic [OPW-1:0] OP_SHR = OPW'(5);
   localparam logic [OPW-1:0] OP_SHL = OPW'(6);
   localparam logic [OPW-1:0] OP_EQ  = OPW'(7);
   localparam logic [OPW-1:0] OP_NE  = OPW'(8);
   localparam logic [OPW-1:0] OP_LDA = OPW'(9);
   localparam logic [OPW-1:0] OP_STA = OPW'(10);
   localparam logic [OPW-1:0] OP_MUL = OPW'(11);
   localparam logic [OPW-1:0] OP_SLT = OPW'(12);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;

   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic             big_shift;
   logic             op_ok;
   logic [WIDTH-1:0] res_c;
   logic             cmp_c;
   logic             carry_c;
   logic             ovf_c;
   logic             zero_c;
   logic             neg_c;
   logic [WIDTH-1:0] mul_next;
   logic             accept;
   logic             is_mul;

   assign in_ready = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
   assign accept   = in_valid & in_ready;
   assign is_mul   = alu_src & (opcode == OP_MUL);
   assign mul_next = acc + (mplier[0] ? mcand : '0);

   always_comb begin
      add_w     = {1'b0, data_in1} + {1'b0, data_in2};
      sub_w     = {1'b0, data_in1} - {1'b0, data_in2};
      big_shift = ({1'b0, data_in2} >= W_LIM);
      op_ok     = 1'b1;
      res_c     = '0;
      cmp_c     = 1'b0;
      carry_c   = 1'b0;
      ovf_c     = 1'b0;
      case (opcode)
         OP_ADD, OP_LDA, OP_STA: begin
            res_c   = add_w[M:0];
            carry_c = add_w[WIDTH];
            ovf_c   = (data_in1[M] == data_in2[M]) && (add_w[M] != data_in1[M]);
         end
         OP_SUB: begin
            res_c   = sub_w[M:0];
            carry_c = sub_w[WIDTH];
            ovf_c   = (data_in1[M] != data_in2[M]) && (sub_w[M] != data_in1[M]);
         end
         OP_AND:  res_c = data_in1 & data_in2;
         OP_OR:   res_c = data_in1 | data_in2;
         OP_XOR:  res_c = data_in1 ^ data_in2;
         OP_SHR:  res_c = big_shift ? '0 : data_in1 >> data_in2;
         OP_SHL:  res_c = big_shift ? '0 : data_in1 << data_in2;
         OP_EQ:   cmp_c = (data_in1 == data_in2);
         OP_NE:   cmp_c = (data_in1 != data_in2);
         OP_SLT:  cmp_c = ($signed(data_in1) < $signed(data_in2));
         OP_MUL:  res_c = '0;
         default: op_ok = 1'b0;
      endcase
      // Bypassed or undefined ops report all-zero flags, zero flag included.
      if (!alu_src || !op_ok) begin
         res_c   = '0;
         cmp_c   = 1'b0;
         carry_c = 1'b0;
         ovf_c   = 1'b0;
      end
      zero_c = alu_src & op_ok & (res_c == '0);
      neg_c  = res_c[M];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         compare   <= 1'b0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         negative  <= 1'b0;
         overflow  <= 1'b0;
      end else if (accept) begin
         if (is_mul) begin
            state     <= BUSY;
            busy      <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= CW'(WIDTH);
            mcand     <= data_in1;
            mplier    <= data_in2;
            acc       <= '0;
         end else begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= res_c;
            compare   <= cmp_c;
            zero      <= zero_c;
            carry     <= carry_c;
            negative  <= neg_c;
            overflow  <= ovf_c;
         end
      end else begin
         case (state)
            BUSY: begin
               acc    <= mul_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  result    <= mul_next;
                  compare   <= 1'b0;
                  zero      <= (mul_next == '0);
                  carry     <= 1'b0;
                  negative  <= mul_next[M];
                  overflow  <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: reference model feeds a scoreboard queue, outputs checked on handshake.
module tb_seq_alu;

   typedef struct packed {
      logic [7:0] res;
      logic       cmp;
      logic       z;
      logic       c;
      logic       n;
      logic       v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] opcode = 4'd0;
   logic       alu_src = 1'b1;
   logic [7:0] a = 8'd0;
   logic [7:0] b = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic       compare, zero, carry, negative, overflow, busy;

   exp_t  sb_q[$];
   string tag_q[$];
   string cur_tag = "none";
   int    n_pass = 0;
   int    n_total = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(8), .OPW(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .alu_src(alu_src), .data_in1(a), .data_in2(b),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .compare(compare), .zero(zero), .carry(carry), .negative(negative),
      .overflow(overflow), .busy(busy)
   );

   function automatic exp_t model(input logic [3:0] op, input logic src,
                                  input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      int ux, uy, sx, sy, r;
      e  = '0;
      ux = x;
      uy = y;
      sx = $signed(x);
      sy = $signed(y);
      if (!src) return e;
      case (op)
         4'd0, 4'd9, 4'd10: begin
            r = ux + uy;
            e.res = r[7:0];
            e.c = (r > 255);
            e.v = (sx + sy > 127) || (sx + sy < -128);
         end
         4'd1: begin
            r = ux - uy;
            e.res = r[7:0];
            e.c = (ux < uy);
            e.v = (sx - sy > 127) || (sx - sy < -128);
         end
         4'd2: e.res = x & y;
         4'd3: e.res = x | y;
         4'd4: e.res = x ^ y;
         4'd5: begin r = (uy >= 8) ? 0 : (ux >> uy); e.res = r[7:0]; end
         4'd6: begin r = (uy >= 8) ? 0 : (ux << uy); e.res = r[7:0]; end
         4'd7: e.cmp = (x == y);
         4'd8: e.cmp = (x != y);
         4'd11: begin r = ux * uy; e.res = r[7:0]; end
         4'd12: e.cmp = (sx < sy);
         default: return e;
      endcase
      e.z = (e.res == 8'd0);
      e.n = e.res[7];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // One clock: record handshakes before the edge, score them after it.
   task automatic cycle();
      logic  fo, fi;
      exp_t  got, e;
      string t;
      fo  = ((out_valid & out_ready) === 1'b1);
      fi  = ((in_valid & in_ready) === 1'b1);
      got = {result, compare, zero, carry, negative, overflow};
      if (fi) begin
         sb_q.push_back(model(opcode, alu_src, a, b));
         tag_q.push_back(cur_tag);
      end
      @(posedge clk);
      #1;
      if (fo) begin
         chk("sb_underflow", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            chk({t, ".result"}, 32'(got.res), 32'(e.res));
            chk({t, ".compare"}, 32'(got.cmp), 32'(e.cmp));
            chk({t, ".flags_zcnv"}, 32'({got.z, got.c, got.n, got.v}),
                32'({e.z, e.c, e.n, e.v}));
         end
      end
   endtask

   task automatic drive(input string t, input logic [3:0] op, input logic src,
                        input logic [7:0] x, input logic [7:0] y);
      cur_tag  = t;
      opcode   = op;
      alu_src  = src;
      a        = x;
      b        = y;
      in_valid = 1'b1;
   endtask

   task automatic send(input string t, input logic [3:0] op, input logic src,
                       input logic [7:0] x, input logic [7:0] y);
      drive(t, op, src, x, y);
      cycle();
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive("rst_req", 4'd0, 1'b1, 8'd1, 8'd1);
      cycle();
      cycle();
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.result", 32'(result), 32'd0);
      chk("rst.flags", 32'({compare, zero, carry, negative, overflow}), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      chk("rel.in_ready", 32'(in_ready), 32'd1);

      send("add_ovf", 4'd0, 1'b1, 8'h7F, 8'h01);
      chk("lat1.out_valid", 32'(out_valid), 32'd1);
      send("add_carry", 4'd0, 1'b1, 8'hFF, 8'h01);
      send("sub_borrow", 4'd1, 1'b1, 8'h03, 8'h05);
      send("sub_ovf", 4'd1, 1'b1, 8'h80, 8'h01);
      send("shl_1", 4'd6, 1'b1, 8'h81, 8'h01);
      send("shr_9", 4'd5, 1'b1, 8'h80, 8'h09);
      send("shr_3", 4'd5, 1'b1, 8'hF0, 8'h03);
      send("ne_eq", 4'd8, 1'b1, 8'h05, 8'h05);
      send("slt_neg", 4'd12, 1'b1, 8'hFF, 8'h01);
      send("slt_pos", 4'd12, 1'b1, 8'h01, 8'hFF);
      send("eq_src0", 4'd7, 1'b0, 8'h05, 8'h05);
      send("eq_true", 4'd7, 1'b1, 8'h33, 8'h33);
      send("and", 4'd2, 1'b1, 8'hCC, 8'hAA);
      send("or", 4'd3, 1'b1, 8'h0C, 8'h81);
      send("xor", 4'd4, 1'b1, 8'hFF, 8'hFF);
      send("ld_addr", 4'd9, 1'b1, 8'h40, 8'h40);
      send("st_addr", 4'd10, 1'b1, 8'hF0, 8'h20);
      send("unused_op", 4'd13, 1'b1, 8'h00, 8'h00);
      in_valid = 1'b0;
      cycle();
      chk("stream.drained", 32'(sb_q.size()), 32'd0);
      chk("stream.out_valid_low", 32'(out_valid), 32'd0);

      send("mul_13x11", 4'd11, 1'b1, 8'd13, 8'd11);
      in_valid = 1'b0;
      a = 8'hFF;
      b = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("mul.busy%0d", i), 32'(busy), 32'd1);
         chk($sformatf("mul.in_ready%0d", i), 32'(in_ready), 32'd0);
         chk($sformatf("mul.out_valid%0d", i), 32'(out_valid), 32'd0);
         cycle();
      end
      chk("mul.done_valid", 32'(out_valid), 32'd1);
      chk("mul.done_busy", 32'(busy), 32'd0);
      chk("mul.result_direct", 32'(result), 32'h8F);
      cycle();
      chk("mul.drained", 32'(sb_q.size()), 32'd0);

      out_ready = 1'b0;
      send("bp_add", 4'd0, 1'b1, 8'd1, 8'd2);
      drive("bp_sub", 4'd1, 1'b1, 8'd9, 8'd4);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp.valid%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp.result%0d", i), 32'(result), 32'd3);
         chk($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
         cycle();
      end
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_release", 32'(in_ready), 32'd1);
      cycle();
      in_valid = 1'b0;
      chk("bp.sub_valid", 32'(out_valid), 32'd1);
      chk("bp.sub_result_direct", 32'(result), 32'd5);
      cycle();
      chk("bp.drained", 32'(sb_q.size()), 32'd0);

      send("mul_rst", 4'd11, 1'b1, 8'd6, 8'd7);
      in_valid = 1'b0;
      cycle();
      cycle();
      cycle();
      rst_n = 1'b0;
      cycle();
      sb_q.delete();
      tag_q.delete();
      chk("mrst.busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("mrst.out_valid%0d", i), 32'(out_valid), 32'd0);
         cycle();
      end
      send("post_rst_add", 4'd0, 1'b1, 8'd2, 8'd2);
      in_valid = 1'b0;
      chk("post_rst.lat1", 32'(out_valid), 32'd1);
      cycle();
      chk("final.drained", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
